msg_sequencer: RTL and testbench



---
 rtl/msg_seq_pkg.sv | 9 +
 rtl/msg_seq_timer.sv | 18 +
 rtl/msg_sequencer.sv | 100 ++++++++++
 tb/tb_msg_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/msg_seq_pkg.sv
// msg_seq_pkg: message ROM, blank code and state encoding shared by msg_sequencer.
package msg_seq_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;
    localparam logic [7:0] ASCII_BLANK = 8'h00;
    localparam logic [7:0] MSG_ROM [16] = '{
        8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
endpackage

// File: rtl/msg_seq_timer.sv
// msg_seq_timer: clearable run-enabled counter, expire is high while running at terminal count.
module msg_seq_timer #(
    parameter int W = 2
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Clr,
    input  logic         i_Run,
    input  logic [W-1:0] i_Tc,
    output logic         o_Expire
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = i_Clr ? '0 : i_Run ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    assign o_Expire = i_Run && (cnt_q == i_Tc);
endmodule

// File: rtl/msg_sequencer.sv
// msg_sequencer: steps a ROM message onto one 7-seg digit with blank gaps between characters.
// Define MSG_SEQ_AUTOPLAY_EN to enable i_Play auto-advance and looping.
module msg_sequencer
    import msg_seq_pkg::*;
#(
    parameter int CLKS_PER_CHAR = 12_500_000,
    parameter int GAP_CLKS      = 2_500_000,
    parameter int MSG_LEN       = 5
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Step,
    input  logic       i_Play,
    output logic [7:0] o_Ascii,
    output logic [3:0] o_Char_Index,
    output logic       o_Busy,
    output logic       o_Done
);
    localparam int MAX_CLKS = CLKS_PER_CHAR > GAP_CLKS ? CLKS_PER_CHAR : GAP_CLKS;
    localparam int TW = $clog2(MAX_CLKS);
    localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          step_q, step_prev_q, step_edge;
    logic          play, run, expire;
    logic [TW-1:0] tc;

`ifdef MSG_SEQ_AUTOPLAY_EN
    assign play = i_Play;
    assign tc   = state_q == SHOW ? TW'(CLKS_PER_CHAR - 1) : TW'(GAP_CLKS - 1);
`else
    logic unused_play;
    assign unused_play = i_Play;
    assign play = 1'b0;
    assign tc   = TW'(GAP_CLKS - 1);
`endif

    // Edge is taken between two registered samples so a step reacts one edge after it is sampled.
    assign step_edge = step_q && !step_prev_q;
    assign run = state_q == GAP || (state_q == SHOW && play);

    msg_seq_timer #(.W(TW)) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clr   (state_d != state_q),
        .i_Run   (run),
        .i_Tc    (tc),
        .o_Expire(expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (step_edge || play) begin
                state_d = SHOW;
                idx_d   = '0;
            end
            SHOW: if (step_edge || expire) begin
                state_d = GAP;
                done_d  = idx_q == LAST;
            end
            GAP: if (expire) begin
                state_d = idx_q != LAST || play ? SHOW : IDLE;
                idx_d   = idx_q != LAST ? idx_q + 4'd1 : 4'd0;
            end
            default: state_d = IDLE;
        endcase
        ascii_d = state_d == SHOW ? MSG_ROM[idx_d] : ASCII_BLANK;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ascii_q     <= ASCII_BLANK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ascii_q     <= ascii_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_q      <= i_Step;
            step_prev_q <= step_q;
        end

    assign o_Ascii      = ascii_q;
    assign o_Char_Index = idx_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
endmodule

// File: tb/tb_msg_sequencer.sv
// tb_msg_sequencer: directed checks of stepping, gaps, done, held/ignored steps, async reset and auto-play.
module tb_msg_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic       play = 1'b0;
    logic [7:0] ascii;
    logic [3:0] idx;
    logic       busy, done;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_msg [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    msg_sequencer #(.CLKS_PER_CHAR(4), .GAP_CLKS(2), .MSG_LEN(5)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Step      (step),
        .i_Play      (play),
        .o_Ascii     (ascii),
        .o_Char_Index(idx),
        .o_Busy      (busy),
        .o_Done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step  = 1'b0;
        play  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One step pulse from SHOW: old char holds one more cycle, then a 2-cycle gap, then nxt.
    task automatic step_adv(input logic [7:0] cur, input logic [7:0] nxt, input logic [3:0] nidx, input logic dn);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_pre", ascii, cur);
        tick();
        chk("gap1_blank", ascii, 8'h00);
        chk("gap1_done", {7'd0, done}, {7'd0, dn});
        chk("gap1_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("gap2_blank", ascii, 8'h00);
        chk("gap2_done", {7'd0, done}, 8'd0);
        tick();
        chk("next_ascii", ascii, nxt);
        chk("next_idx", {4'd0, idx}, {4'd0, nidx});
        chk("next_busy", {7'd0, busy}, {7'd0, !dn});
        repeat (6) tick();
    endtask

    initial begin
        do_reset();
        repeat (10) tick();
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_idx", {4'd0, idx}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);

`ifdef MSG_SEQ_AUTOPLAY_EN
        play = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("play_char", ascii, exp_msg[k]);
                chk("play_idx", {4'd0, idx}, 8'(k));
                tick();
            end
            for (int j = 0; j < 2; j++) begin
                chk("play_gap", ascii, 8'h00);
                chk("play_done", {7'd0, done}, {7'd0, (j == 0 && k == 4)});
                tick();
            end
        end
        chk("play_wrap", ascii, 8'h48);
        chk("play_wrap_idx", {4'd0, idx}, 8'd0);
        play = 1'b0;
        repeat (10) tick();
        chk("play_off_hold", ascii, 8'h48);
        step_adv(8'h48, 8'h45, 4'd1, 1'b0);
`else
        play = 1'b1;
        repeat (10) tick();
        chk("play_ignored_ascii", ascii, 8'h00);
        chk("play_ignored_busy", {7'd0, busy}, 8'd0);
`endif

        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("first_pre", ascii, 8'h00);
        tick();
        chk("first_ascii", ascii, 8'h48);
        chk("first_idx", {4'd0, idx}, 8'd0);
        chk("first_busy", {7'd0, busy}, 8'd1);
        repeat (8) tick();
        chk("first_hold", ascii, 8'h48);
        step_adv(8'h48, 8'h45, 4'd1, 1'b0);
        step_adv(8'h45, 8'h4C, 4'd2, 1'b0);
        step_adv(8'h4C, 8'h4C, 4'd3, 1'b0);
        step_adv(8'h4C, 8'h4F, 4'd4, 1'b0);
        step_adv(8'h4F, 8'h00, 4'd0, 1'b1);

        step = 1'b1;
        repeat (50) tick();
        chk("held_ascii", ascii, 8'h48);
        chk("held_idx", {4'd0, idx}, 8'd0);
        step = 1'b0;
        repeat (3) tick();
        chk("held_after", ascii, 8'h48);

        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("gapstep_gap", ascii, 8'h00);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("gapstep_gap2", ascii, 8'h00);
        tick();
        chk("gapstep_next", ascii, 8'h45);
        chk("gapstep_idx", {4'd0, idx}, 8'd1);
        repeat (5) tick();
        chk("gapstep_dropped", ascii, 8'h45);
        chk("gapstep_dropped_idx", {4'd0, idx}, 8'd1);

        step_adv(8'h45, 8'h4C, 4'd2, 1'b0);
        step_adv(8'h4C, 8'h4C, 4'd3, 1'b0);
        chk("pre_rst_idx", {4'd0, idx}, 8'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ascii", ascii, 8'h00);
        chk("async_idx", {4'd0, idx}, 8'd0);
        chk("async_busy", {7'd0, busy}, 8'd0);
        chk("async_done", {7'd0, done}, 8'd0);
        tick();
        chk("rst_hold_done", {7'd0, done}, 8'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_ascii", ascii, 8'h00);
        chk("post_rst_done", {7'd0, done}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
